// File: rtl/hilo_mdu.sv
// HI/LO register pair with single-cycle MULT/MULTU/MTHI/MTLO and a 32-iteration restoring divider.
// Divides hold stall_o high from issue through the last iteration; the result lands one cycle later.
module hilo_mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena_i,
  input  logic [5:0]  funct_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [5:0] FunctMult  = 6'h18;
  localparam logic [5:0] FunctMultu = 6'h19;
  localparam logic [5:0] FunctDiv   = 6'h1A;
  localparam logic [5:0] FunctDivu  = 6'h1B;
  localparam logic [5:0] FunctMthi  = 6'h11;
  localparam logic [5:0] FunctMtlo  = 6'h13;

  typedef enum logic [1:0] {Idle, DivRun, DivFix} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic        sq;
  logic        sr;
  logic [31:0] divisor;
  logic [31:0] rem;
  logic [31:0] quo;

  logic        isDiv;
  logic        isSignedDiv;
  logic        issue;
  logic [63:0] prodS;
  logic [63:0] prodU;
  logic [31:0] aMag;
  logic [31:0] bMag;
  logic [32:0] shifted;
  logic [33:0] diff;

  assign isDiv       = (funct_i == FunctDiv) || (funct_i == FunctDivu);
  assign isSignedDiv = (funct_i == FunctDiv);
  assign issue       = (state == Idle) && ena_i && !flush_i;
  assign stall_o     = (issue && isDiv) || ((state == DivRun) && !flush_i);

  assign prodS = $signed({{32{src_a_i[31]}}, src_a_i}) * $signed({{32{src_b_i[31]}}, src_b_i});
  assign prodU = {32'd0, src_a_i} * {32'd0, src_b_i};

  // The most negative dividend maps to magnitude 0x80000000, which the unsigned datapath holds exactly.
  assign aMag = (isSignedDiv && src_a_i[31]) ? (~src_a_i + 32'd1) : src_a_i;
  assign bMag = (isSignedDiv && src_b_i[31]) ? (~src_b_i + 32'd1) : src_b_i;

  assign shifted = {rem, quo[31]};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= Idle;
      cnt     <= 6'd0;
      sq      <= 1'b0;
      sr      <= 1'b0;
      divisor <= 32'd0;
      rem     <= 32'd0;
      quo     <= 32'd0;
      hi_o    <= 32'd0;
      lo_o    <= 32'd0;
    end else if (flush_i) begin
      state <= Idle;
      cnt   <= 6'd0;
    end else begin
      case (state)
        Idle: begin
          if (ena_i) begin
            case (funct_i)
              FunctMult:  {hi_o, lo_o} <= prodS;
              FunctMultu: {hi_o, lo_o} <= prodU;
              FunctMthi:  hi_o <= src_a_i;
              FunctMtlo:  lo_o <= src_a_i;
              FunctDiv, FunctDivu: begin
                divisor <= bMag;
                quo     <= aMag;
                rem     <= 32'd0;
                cnt     <= 6'd0;
                sq      <= isSignedDiv && (src_a_i[31] ^ src_b_i[31]);
                sr      <= isSignedDiv && src_a_i[31];
                state   <= DivRun;
              end
              default: ;
            endcase
          end
        end
        DivRun: begin
          // A zero divisor always "succeeds", yielding all-ones quotient and the dividend as remainder.
          if (!diff[33]) begin
            rem <= diff[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= shifted[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= DivFix;
        end
        DivFix: begin
          lo_o  <= sq ? (~quo + 32'd1) : quo;
          hi_o  <= sr ? (~rem + 32'd1) : rem;
          state <= Idle;
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Scoreboard bench for hilo_mdu: the driver pushes per-cycle expectations from an arithmetic model,
// and a negedge monitor pops and compares hi_o, lo_o and stall_o.
module tb_hilo_mdu;

  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MTLO  = 6'h13;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena_i;
  logic [5:0]  funct_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  hilo_mdu dut (
    .clk     (clk),
    .rst     (rst),
    .ena_i   (ena_i),
    .funct_i (funct_i),
    .src_a_i (src_a_i),
    .src_b_i (src_b_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        mon;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      mon = sbQ.pop_front();
      chk("align", cyc, mon.due);
      chk("hi", hi_o, mon.hi);
      chk("lo", lo_o, mon.lo);
      chk("stall", {31'd0, stall_o}, {31'd0, mon.stall});
    end
  end

  // One pipeline cycle: drive inputs, record what the outputs must show during it.
  task automatic step(input logic e, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic fl, input logic r, input logic expStall);
    ena_i   = e;
    funct_i = f;
    src_a_i = a;
    src_b_i = b;
    flush_i = fl;
    rst     = r;
    sbQ.push_back('{due: cyc, hi: mHi, lo: mLo, stall: expStall});
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic e, input logic fl);
    longint      sp;
    logic [63:0] up;
    step(e, f, a, b, fl, 1'b0, 1'b0);
    if (e && !fl) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      up = 64'(a) * 64'(b);
      case (f)
        MULT:    {mHi, mLo} = sp;
        MULTU:   {mHi, mLo} = up;
        MTHI:    mHi = a;
        MTLO:    mLo = a;
        default: ;
      endcase
    end
  endtask

  task automatic divRef(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl);
    logic        sa, sb;
    logic [31:0] am, bm, qm, rm;
    sa = sgn && a[31];
    sb = sgn && b[31];
    am = sa ? -a : a;
    bm = sb ? -b : b;
    if (bm == 0) begin
      qm = 32'hFFFFFFFF;
      rm = am;
    end else begin
      qm = am / bm;
      rm = am % bm;
    end
    rl = (sa ^ sb) ? -qm : qm;
    rh = sa ? -rm : rm;
  endtask

  // Divide of 34 cycles (issue, 32 iterations, fix) with optional flush or reset at cycle index.
  task automatic doDiv(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int flushAt, input int rstAt, input logic holdEna);
    logic [31:0] rh, rl;
    logic        e, fl, r;
    divRef(f == DIV, a, b, rh, rl);
    for (int t = 0; t <= 33; t++) begin
      fl = (t == flushAt);
      r  = (t == rstAt);
      e  = (t == 0) ? 1'b1 : (holdEna ? 1'b1 : 1'($urandom_range(0, 1)));
      step(e, f, a, b, fl, r, (t <= 32) && !fl);
      if (r) begin
        mHi = 32'd0;
        mLo = 32'd0;
        return;
      end
      if (fl) return;
    end
    mHi = rh;
    mLo = rl;
  endtask

  function automatic logic [31:0] rndVal();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] badF [4];
    badF[0] = 6'h10;
    badF[1] = 6'h12;
    badF[2] = 6'h20;
    badF[3] = 6'h00;

    rst = 1'b1; ena_i = 1'b0; funct_i = 6'h00; src_a_i = 32'd0; src_b_i = 32'd0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    step(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    op(MULT, 32'hFFFFFFFD, 32'd5, 1'b1, 1'b0);
    op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    op(MTLO, 32'h12345678, 32'd0, 1'b1, 1'b0);
    doDiv(DIV, 32'hFFFFFFF9, 32'd2, -1, -1, 1'b0);
    doDiv(DIVU, 32'd100, 32'd7, -1, -1, 1'b0);
    doDiv(DIVU, 32'd7, 32'd0, -1, -1, 1'b0);
    doDiv(DIV, 32'hFFFFFFF8, 32'd0, -1, -1, 1'b0);
    doDiv(DIV, 32'h80000000, 32'hFFFFFFFF, -1, -1, 1'b0);

    op(MTHI, 32'hAAAAAAAA, 32'd0, 1'b1, 1'b0);
    op(MTLO, 32'h55555555, 32'd0, 1'b1, 1'b0);
    doDiv(DIV, 32'd1000, 32'd3, 10, -1, 1'b1);
    op(MULT, 32'd2, 32'd3, 1'b1, 1'b0);

    doDiv(DIVU, 32'hDEADBEEF, 32'd13, -1, 20, 1'b1);
    step(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    doDiv(DIV, 32'hFFFF0000, 32'd77, -1, -1, 1'b1);
    step(1'b0, DIV, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    op(MTHI, 32'hCAFEF00D, 32'd0, 1'b1, 1'b1);
    doDiv(DIVU, 32'd50, 32'd5, 33, -1, 1'b1);
    doDiv(DIV, 32'd50, 32'd5, 0, -1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:    op(MULT, rndVal(), rndVal(), 1'b1, ($urandom_range(0, 7) == 0));
        1:    op(MULTU, rndVal(), rndVal(), 1'b1, ($urandom_range(0, 7) == 0));
        2:    op(MTHI, rndVal(), rndVal(), 1'b1, ($urandom_range(0, 7) == 0));
        3:    op(MTLO, rndVal(), rndVal(), 1'b1, ($urandom_range(0, 7) == 0));
        4:    op(badF[$urandom_range(0, 3)], rndVal(), rndVal(), 1'b1, 1'b0);
        5:    op(DIV, rndVal(), rndVal(), 1'b0, 1'b0);
        6, 7: doDiv(($urandom_range(0, 1) == 1) ? DIV : DIVU, rndVal(), rndVal(), -1, -1,
                    1'($urandom_range(0, 1)));
        8:    doDiv(($urandom_range(0, 1) == 1) ? DIV : DIVU, rndVal(), rndVal(),
                    $urandom_range(0, 33), -1, 1'b1);
        default: doDiv(($urandom_range(0, 1) == 1) ? DIV : DIVU, rndVal(), rndVal(), -1,
                       $urandom_range(1, 33), 1'b1);
      endcase
    end
    step(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    chk("drain", sbQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
